// File: rtl/qupls4_queue_bank.sv
// qupls4_queue_bank: 16 independent circular hardware queues that answer
// the queue manager (one-hot rst/rd/wr strobes) and a hardware push port.
// Ports: clk, rst (sync, active-low); q_rst/q_rd/q_wr one-hot strobes;
//   q_addr (bit15 peek, low bits peek offset); q_wr_data sw push data;
//   hw_push/hw_qid/hw_data hw producer; q_rd_data per-queue read result
//   (2-edge latency, held); q_count/q_empty/q_full/q_ovf/q_unf status.
module qupls4_queue_bank #(
  parameter int NQ        = 16,
  parameter int DEPTH_LOG = 4,
  parameter int WID       = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NQ-1:0]                q_rst,
  input  logic [NQ-1:0]                q_rd,
  input  logic [NQ-1:0]                q_wr,
  input  logic [15:0]                  q_addr,
  input  logic [WID-1:0]               q_wr_data,
  input  logic                         hw_push,
  input  logic [3:0]                   hw_qid,
  input  logic [WID-1:0]               hw_data,
  output logic [NQ*WID-1:0]            q_rd_data,
  output logic [NQ*(DEPTH_LOG+1)-1:0]  q_count,
  output logic [NQ-1:0]                q_empty,
  output logic [NQ-1:0]                q_full,
  output logic [NQ-1:0]                q_ovf,
  output logic [NQ-1:0]                q_unf
);

  localparam int DEPTH = 2**DEPTH_LOG;
  localparam int CW    = DEPTH_LOG + 1;
  localparam int PW    = DEPTH_LOG;

  logic [WID-1:0] mem_q [NQ][DEPTH];

  logic [PW-1:0]  head_q [NQ];
  logic [PW-1:0]  head_d [NQ];
  logic [PW-1:0]  tail_q [NQ];
  logic [PW-1:0]  tail_d [NQ];
  logic [CW-1:0]  cnt_q  [NQ];
  logic [CW-1:0]  cnt_d  [NQ];
  logic [CW:0]    free   [NQ];
  logic [PW-1:0]  rd_idx [NQ];

  logic [NQ-1:0]  ovf_q, ovf_d;
  logic [NQ-1:0]  unf_q, unf_d;
  logic [NQ-1:0]  empty_q, full_q;
  logic [NQ-1:0]  hw_sel, hw_acc, sw_acc;
  logic [NQ-1:0]  pop, rd_ok, drop;

  logic [NQ-1:0]  s1_vld_q, s2_vld_q;
  logic [WID-1:0] s1_dat_q [NQ];
  logic [WID-1:0] s2_dat_q [NQ];
  logic [WID-1:0] rdo_q    [NQ];

  logic           peek;
  logic [PW-1:0]  off;
  logic           unused_addr;

  assign peek        = q_addr[15];
  assign off         = q_addr[PW-1:0];
  assign unused_addr = ^q_addr[14:PW];

  always_comb begin
    hw_sel = '0;
    hw_acc = '0;
    sw_acc = '0;
    pop    = '0;
    rd_ok  = '0;
    drop   = '0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    for (int i = 0; i < NQ; i++) begin
      hw_sel[i] = hw_push && (hw_qid == 4'(i));
      rd_ok[i]  = peek ? ({1'b0, off} < cnt_q[i])
                       : (cnt_q[i] != '0);
      rd_idx[i] = head_q[i] + (peek ? off : '0);
      pop[i]    = !q_rst[i] && q_rd[i] && !peek
                  && (cnt_q[i] != '0);
      // a same-cycle pop frees one slot for the pushes
      free[i]   = (CW+1)'(DEPTH) - (CW+1)'(cnt_q[i])
                  + (CW+1)'(pop[i]);
      hw_acc[i] = !q_rst[i] && hw_sel[i] && (free[i] != '0);
      sw_acc[i] = !q_rst[i] && q_wr[i]
                  && (free[i] > (CW+1)'(hw_acc[i]));
      drop[i]   = (hw_sel[i] && !hw_acc[i])
                  || (q_wr[i] && !sw_acc[i]);
      if (q_rst[i]) begin
        head_d[i] = '0;
        tail_d[i] = '0;
        cnt_d[i]  = '0;
        ovf_d[i]  = 1'b0;
        unf_d[i]  = 1'b0;
      end else begin
        head_d[i] = head_q[i] + PW'(pop[i]);
        tail_d[i] = tail_q[i] + PW'(hw_acc[i])
                    + PW'(sw_acc[i]);
        cnt_d[i]  = cnt_q[i] + CW'(hw_acc[i])
                    + CW'(sw_acc[i]) - CW'(pop[i]);
        ovf_d[i]  = ovf_q[i] | drop[i];
        unf_d[i]  = unf_q[i] | (q_rd[i] & !rd_ok[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NQ; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ovf_q   <= '0;
      unf_q   <= '0;
      empty_q <= '1;
      full_q  <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        cnt_q[i]   <= cnt_d[i];
        empty_q[i] <= (cnt_d[i] == '0);
        full_q[i]  <= (cnt_d[i] == CW'(DEPTH));
      end
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // hw push lands first, sw push in the slot after it
  always_ff @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (hw_acc[i])
        mem_q[i][tail_q[i]] <= hw_data;
      if (sw_acc[i])
        mem_q[i][tail_q[i] + PW'(hw_acc[i])] <= q_wr_data;
    end
  end

  // data is captured at the sampling edge so a push into
  // the slot just freed by this pop cannot corrupt it
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q <= '0;
      s2_vld_q <= '0;
      for (int i = 0; i < NQ; i++) begin
        s1_dat_q[i] <= '0;
        s2_dat_q[i] <= '0;
        rdo_q[i]    <= '0;
      end
    end else begin
      s1_vld_q <= q_rd & ~q_rst;
      s2_vld_q <= s1_vld_q;
      for (int i = 0; i < NQ; i++) begin
        s1_dat_q[i] <= rd_ok[i] ? mem_q[i][rd_idx[i]] : '0;
        s2_dat_q[i] <= s1_dat_q[i];
        if (s2_vld_q[i])
          rdo_q[i] <= s2_dat_q[i];
      end
    end
  end

  for (genvar g = 0; g < NQ; g++) begin : g_out
    assign q_rd_data[g*WID +: WID] = rdo_q[g];
    assign q_count[g*CW +: CW]     = cnt_q[g];
  end

  assign q_empty = empty_q;
  assign q_full  = full_q;
  assign q_ovf   = ovf_q;
  assign q_unf   = unf_q;

endmodule

// File: tb/tb_qupls4_queue_bank.sv
// tb_qupls4_queue_bank: scoreboard bench with a queue-based
// reference model for qupls4_queue_bank.
module tb_qupls4_queue_bank;

  localparam int NQ = 16;
  localparam int D  = 16;
  localparam int W  = 64;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NQ-1:0]      q_rst, q_rd, q_wr;
  logic [15:0]        q_addr;
  logic [W-1:0]       q_wr_data, hw_data;
  logic               hw_push;
  logic [3:0]         hw_qid;
  logic [NQ*W-1:0]    q_rd_data;
  logic [NQ*CW-1:0]   q_count;
  logic [NQ-1:0]      q_empty, q_full, q_ovf, q_unf;

  qupls4_queue_bank dut (
    .clk(clk), .rst(rst),
    .q_rst(q_rst), .q_rd(q_rd), .q_wr(q_wr),
    .q_addr(q_addr), .q_wr_data(q_wr_data),
    .hw_push(hw_push), .hw_qid(hw_qid),
    .hw_data(hw_data),
    .q_rd_data(q_rd_data), .q_count(q_count),
    .q_empty(q_empty), .q_full(q_full),
    .q_ovf(q_ovf), .q_unf(q_unf)
  );

  typedef struct {
    int         due;
    int         q;
    logic [W-1:0] d;
  } rd_t;

  typedef struct {
    int            due;
    bit            r;
    logic [79:0]   cnt;
    logic [15:0]   emp, ful, ovf, unf;
  } st_t;

  rd_t          rdq[$];
  st_t          stq[$];
  logic [W-1:0] mq[NQ][$];
  logic [15:0]  m_ovf, m_unf;
  logic [W-1:0] held[NQ];
  int           cyc = 0;
  int           npass = 0;
  int           ntot = 0;
  bit           armed = 0;
  rd_t          mr;
  st_t          ms;

  task automatic chk(string nm, int idx,
                     logic [79:0] act, logic [79:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s[%0d] cyc %0d got %h want %h",
                  nm, idx, cyc, act, exp);
  endtask

  task automatic model();
    st_t          s;
    logic [W-1:0] v;
    int           off;
    s.r = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NQ; i++) mq[i].delete();
      m_ovf = '0;
      m_unf = '0;
      rdq.delete();
      s.r = 1'b1;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        if (q_rst[i]) begin
          mq[i].delete();
          m_ovf[i] = 1'b0;
          m_unf[i] = 1'b0;
        end else begin
          if (q_rd[i]) begin
            v   = '0;
            off = int'(q_addr[3:0]);
            if (q_addr[15]) begin
              if (off < mq[i].size()) v = mq[i][off];
              else m_unf[i] = 1'b1;
            end else begin
              if (mq[i].size() > 0) v = mq[i].pop_front();
              else m_unf[i] = 1'b1;
            end
            rdq.push_back('{cyc + 3, i, v});
          end
          if (hw_push && int'(hw_qid) == i) begin
            if (mq[i].size() < D) mq[i].push_back(hw_data);
            else m_ovf[i] = 1'b1;
          end
          if (q_wr[i]) begin
            if (mq[i].size() < D) mq[i].push_back(q_wr_data);
            else m_ovf[i] = 1'b1;
          end
        end
      end
    end
    s.due = cyc + 1;
    for (int i = 0; i < NQ; i++) begin
      s.cnt[i*CW +: CW] = CW'(mq[i].size());
      s.emp[i] = (mq[i].size() == 0);
      s.ful[i] = (mq[i].size() == D);
    end
    s.ovf = m_ovf;
    s.unf = m_unf;
    stq.push_back(s);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    while (rdq.size() > 0 && rdq[0].due == cyc) begin
      mr = rdq.pop_front();
      held[mr.q] = mr.d;
      chk("rd_data", mr.q, 80'(q_rd_data[mr.q*W +: W]),
          80'(mr.d));
    end
    if (stq.size() > 0 && stq[0].due == cyc) begin
      ms = stq.pop_front();
      if (ms.r) begin
        for (int i = 0; i < NQ; i++) held[i] = '0;
        armed = 1'b1;
      end
      chk("count", 0, 80'(q_count), ms.cnt);
      chk("empty", 0, 80'(q_empty), 80'(ms.emp));
      chk("full",  0, 80'(q_full),  80'(ms.ful));
      chk("ovf",   0, 80'(q_ovf),   80'(ms.ovf));
      chk("unf",   0, 80'(q_unf),   80'(ms.unf));
    end
    if (armed)
      for (int i = 0; i < NQ; i++)
        chk("held", i, 80'(q_rd_data[i*W +: W]),
            80'(held[i]));
  end

  task automatic clr();
    rst = 1'b1; q_rst = '0; q_rd = '0; q_wr = '0;
    q_addr = '0; q_wr_data = '0; hw_push = 1'b0;
    hw_qid = '0; hw_data = '0;
  endtask

  task automatic tick();
    model();
    @(negedge clk);
    clr();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic sw(int q, logic [W-1:0] d);
    q_wr[q] = 1'b1; q_wr_data = d; tick();
  endtask

  task automatic hw(int q, logic [W-1:0] d);
    hw_push = 1'b1; hw_qid = 4'(q); hw_data = d; tick();
  endtask

  task automatic pop(int q);
    q_rd[q] = 1'b1; tick();
  endtask

  task automatic peek(int q, int off);
    q_rd[q] = 1'b1;
    q_addr = 16'h8000 | 16'(off);
    tick();
  endtask

  task automatic qreset(int q);
    q_rst[q] = 1'b1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b0; tick();
    rst = 1'b0; tick();
    // basic push/pop on queue 3
    sw(3, 64'hA1); sw(3, 64'hA2);
    pop(3); pop(3); idle(4);
    // fill queue 14 from the hw port, overflow, drain with wrap
    for (int k = 0; k < 17; k++) hw(14, 64'h1400 + 64'(k));
    for (int k = 0; k < 16; k++) pop(14);
    idle(4);
    // dual push, then dual push with one free slot
    q_wr[5] = 1'b1; q_wr_data = 64'h22;
    hw_push = 1'b1; hw_qid = 4'd5; hw_data = 64'h11;
    tick();
    pop(5); pop(5); idle(3);
    for (int k = 0; k < 15; k++) sw(5, 64'h500 + 64'(k));
    q_wr[5] = 1'b1; q_wr_data = 64'h22;
    hw_push = 1'b1; hw_qid = 4'd5; hw_data = 64'h11;
    tick();
    for (int k = 0; k < 16; k++) pop(5);
    idle(4);
    // underflow on pop and peek, valid peek
    pop(7); idle(3);
    qreset(7);
    sw(7, 64'h71); sw(7, 64'h72);
    peek(7, 2); idle(3);
    qreset(7);
    sw(7, 64'h71); sw(7, 64'h72); sw(7, 64'h73);
    peek(7, 1); idle(3);
    // queue reset overrides same-cycle write and read
    for (int k = 0; k < 4; k++) sw(2, 64'h200 + 64'(k));
    pop(2); idle(3);
    q_rst[2] = 1'b1; q_wr[2] = 1'b1; q_rd[2] = 1'b1;
    q_wr_data = 64'hDEAD;
    tick();
    idle(4);
    // global reset kills an in-flight read
    sw(0, 64'hC0FFEE);
    pop(0);
    rst = 1'b0; tick();
    idle(4);
    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0)
        q_rst = 16'h1 << $urandom_range(0, 15);
      q_wr = 16'($urandom & $urandom);
      if (k < 250) q_rd = 16'($urandom & $urandom & $urandom);
      else q_rd = 16'($urandom & $urandom);
      q_addr = 16'($urandom);
      if ($urandom_range(0, 2) != 0) q_addr[15] = 1'b0;
      q_wr_data = {$urandom, $urandom};
      hw_push = ($urandom_range(0, 1) == 1);
      hw_qid = ($urandom_range(0, 2) == 0)
               ? 4'd14 : 4'($urandom_range(0, 15));
      hw_data = {$urandom, $urandom};
      tick();
    end
    idle(6);
    chk("drain", 0, 80'(rdq.size() + stq.size()), 80'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/qupls4_queue_bank.md
Name: qupls4_queue_bank

Overview:
- Responder side of the queue-manager interface: holds 16 independent circular hardware queues addressed by one-hot rst/rd/wr strobes.
- Returns popped or peeked entries on per-queue read-data buses with fixed latency.
- Provides a hardware producer push port. Queue 14, the NaN queue, is fed by FPU exception logic through this port.
- Exports per-queue status (count, empty, full, sticky overflow and underflow).

Parameters:
- NQ, 16, number of queues (fixed 16 for the interface width).
- DEPTH_LOG, 4, log2 of entries per queue (DEPTH = 2**DEPTH_LOG).
- WID, 64, entry width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- q_rst  in  16  one-hot per-queue reset pulse.
- q_rd  in  16  per-queue read pulse.
- q_wr  in  16  per-queue write (push) pulse.
- q_addr  in  16  read control: bit15 = peek (no pop); [DEPTH_LOG-1:0] = offset from head for peek.
- q_wr_data  in  WID  software push data, shared by all set q_wr bits.
- hw_push  in  1  hardware producer push strobe.
- hw_qid  in  4  hardware push target queue.
- hw_data  in  WID  hardware push data.
- q_rd_data  out  WID x16  per-queue read result, held between reads.
- q_count  out  (DEPTH_LOG+1) x16  per-queue occupancy.
- q_empty  out  16  count == 0.
- q_full  out  16  count == DEPTH.
- q_ovf  out  16  sticky, a push was dropped.
- q_unf  out  16  sticky, a read found no valid entry.

Behaviour:
- All state updates on posedge clk.
- When rst is low, all head/tail pointers, counts, q_rd_data, q_ovf and q_unf are cleared to 0. q_empty is then all ones and q_full is 0. Storage contents are don't-care.
- Reset has priority over every in-flight operation. Reads already in the pipeline when rst goes low are discarded; their data never appears on q_rd_data.
- q_rst[i]: head, tail, count, q_ovf[i] and q_unf[i] are cleared next cycle. This overrides a same-cycle q_wr[i], hw_push to i and q_rd[i]; none of them take effect.
- Push order per queue per cycle: hw_push first, then the software write. Both can be accepted in one cycle if two free slots exist.
  - With exactly one free slot, the hardware push is accepted, the software push is dropped, and q_ovf[i] is set.
  - A push to a full queue is dropped and sets q_ovf[i].
  - Tail wraps modulo DEPTH.
- Read, pop (q_addr[15]=0):
  - Non-empty queue: the head entry is captured, and head and count advance in the cycle after q_rd is sampled.
  - Empty queue: no pointer change; q_unf[i] is set and the returned data is 0.
  - A same-cycle push to an empty queue is not visible to that pop.
- Read, peek (q_addr[15]=1):
  - Returns the entry at (head + offset) mod DEPTH. No pointer change.
  - If offset >= count, returns 0 and sets q_unf[i].
- Same-cycle pop and push on a non-full queue: count is unchanged.
- Same-cycle pop and push on a full queue: the push is accepted, because the pop frees a slot.
- Read latency: q_rd sampled at edge T gives q_rd_data[i] updated at edge T+2 (stage 1 memory read, stage 2 output register). The value holds until the next read of that queue.
  - The manager samples at T+3; that constraint is met.
- Back-to-back reads of the same queue in consecutive cycles return successive entries in order.
- Multiple q_rd or q_wr bits in one cycle act on each selected queue independently.
- Status outputs are registered and reflect state after the current edge's updates.
- Width: count is DEPTH_LOG+1 bits. Pointers are DEPTH_LOG bits with natural wrap.

Test Plan:
1. Reset with rst=0 for 2 cycles, then push 0xA1 and 0xA2 to queue 3 via q_wr, then pop twice → q_rd_data[3]=0xA1 at T+2, then 0xA2. q_count[3] goes 2→1→0 and q_empty[3]=1.
2. Push 16 entries to queue 14 via hw_push, then a 17th → q_full[14]=1, q_ovf[14]=1, count stays 16. Pop all 16 → values in order, pointer wrap verified.
3. Same-cycle hw_push (0x11) and q_wr (0x22) to empty queue 5 → count=2; pops return 0x11 then 0x22. Repeat with 15 entries already queued → count=16, q_ovf[5]=1, last popped entry is 0x11.
4. Pop from empty queue 7 → q_rd_data[7]=0, q_unf[7]=1, count stays 0. Peek with q_addr=0x8002 at count=2 → q_unf set, data 0. Peek at offset 1 with count=3 → second entry returned, count unchanged.
5. Same-cycle q_rst[2] with q_wr[2] and q_rd[2] on queue 2 holding 4 entries → count=0, q_ovf[2]=0, q_unf[2]=0, and q_rd_data[2] keeps its old value.
6. rst driven low one cycle after a pop is issued → q_rd_data is all zero, all counts 0, and no late data appears at T+2.
